mc_core_ctrl: RTL and testbench

// - Multi-cycle control FSM for the RV32I core.
// - Sequences each instruction through fetch, decode, execute, memory and writeback using the one-hot pkg::opcode_map from the decoder.
// - Drives the IR/PC/regfile write enables and datapath muxes.
// - Runs the req/gnt/rvalid handshakes to instruction and data memory.
// - Watchdog timer traps on memory hangs.

---
 rtl/mc_core_ctrl_pkg.sv | 43 ++++
 rtl/mc_core_ctrl_mem_wdog.sv | 22 ++
 rtl/mc_core_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mc_core_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_core_ctrl_pkg.sv
// Shared types and opcode-map layout for the multi-cycle RV32I control FSM.
package mc_core_ctrl_pkg;

  localparam int unsigned OPC_W         = 21;
  localparam int unsigned OPC_LOAD      = 0;
  localparam int unsigned OPC_LOAD_FP   = 1;
  localparam int unsigned OPC_MISC_MEM  = 2;
  localparam int unsigned OPC_OP_IMM    = 3;
  localparam int unsigned OPC_AUIPC     = 4;
  localparam int unsigned OPC_OP_IMM_32 = 5;
  localparam int unsigned OPC_STORE     = 6;
  localparam int unsigned OPC_STORE_FP  = 7;
  localparam int unsigned OPC_AMO       = 8;
  localparam int unsigned OPC_OP        = 9;
  localparam int unsigned OPC_LUI       = 10;
  localparam int unsigned OPC_OP_32     = 11;
  localparam int unsigned OPC_MADD      = 12;
  localparam int unsigned OPC_MSUB      = 13;
  localparam int unsigned OPC_NMSUB     = 14;
  localparam int unsigned OPC_NMADD     = 15;
  localparam int unsigned OPC_OP_FP     = 16;
  localparam int unsigned OPC_BRANCH    = 17;
  localparam int unsigned OPC_JALR      = 18;
  localparam int unsigned OPC_JAL       = 19;
  localparam int unsigned OPC_SYSTEM    = 20;

  typedef enum logic [2:0] {FETCH, IWAIT, DECODE, EXEC, MEM, DWAIT, WB, TRAP} ctrl_state_e;
  typedef enum logic [1:0] {PC_PLUS4, PC_REL, PC_JALR} pc_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;
  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_SYSTEM, CAUSE_BUS} trap_cause_e;

  // Opcode classes outside RV32I (FP, atomics, RV64 word ops).
  localparam logic [OPC_W-1:0] OPC_UNSUPPORTED = OPC_W'(
      (32'd1 << OPC_LOAD_FP) | (32'd1 << OPC_STORE_FP) | (32'd1 << OPC_AMO) |
      (32'd1 << OPC_OP_32)   | (32'd1 << OPC_OP_IMM_32) | (32'd1 << OPC_MADD) |
      (32'd1 << OPC_MSUB)    | (32'd1 << OPC_NMSUB)    | (32'd1 << OPC_NMADD) |
      (32'd1 << OPC_OP_FP));

  function automatic logic opc_illegal(input logic [OPC_W-1:0] opc);
    return !$onehot(opc) || (|(opc & OPC_UNSUPPORTED));
  endfunction

endpackage

// File: rtl/mc_core_ctrl_mem_wdog.sv
// Memory handshake watchdog: counts cycles while enabled, flags the last allowed cycle.
module mem_wdog #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TCNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TCNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + TCNT_W'(1);
  end

  assign expire = en && (cnt == TCNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mc_core_ctrl.sv
// Multi-cycle control FSM for the RV32I core: sequencing, bus handshakes, trap handling.
module mc_core_ctrl
  import mc_core_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TCNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] opc,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  ctrl_state_e state_q, state_d;
  trap_cause_e cause_q, cause_d;
  pc_sel_e     pc_sel_d;
  wb_sel_e     wb_sel_d;
  logic        wd_clr, imem_exp, dmem_exp;

  assign wd_clr = (state_d != state_q);

  mem_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT), .TCNT_W(TCNT_W)) u_imem_wdog (
    .clk(clk), .rst(rst), .clr(wd_clr),
    .en(state_q == FETCH || state_q == IWAIT), .expire(imem_exp)
  );

  mem_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT), .TCNT_W(TCNT_W)) u_dmem_wdog (
    .clk(clk), .rst(rst), .clr(wd_clr),
    .en(state_q == MEM || state_q == DWAIT), .expire(dmem_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel_d  = PC_PLUS4;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel_d  = WB_ALU;
    retire    = 1'b0;
    trap      = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_gnt)      state_d = IWAIT;
        else if (imem_exp) begin state_d = TRAP; cause_d = CAUSE_BUS; end
      end
      IWAIT: begin
        if (imem_rvalid) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (imem_exp) begin
          state_d = TRAP; cause_d = CAUSE_BUS;
        end
      end
      DECODE: begin
        if (opc_illegal(opc))     begin state_d = TRAP; cause_d = CAUSE_ILLEGAL; end
        else if (opc[OPC_SYSTEM]) begin state_d = TRAP; cause_d = CAUSE_SYSTEM; end
        else                      state_d = EXEC;
      end
      EXEC: begin
        if (opc[OPC_OP]) begin
          state_d = WB;
        end else if (opc[OPC_OP_IMM] || opc[OPC_LUI]) begin
          alu_b_sel = 1'b1;
          state_d   = WB;
        end else if (opc[OPC_AUIPC]) begin
          alu_a_sel = 1'b1;
          alu_b_sel = 1'b1;
          state_d   = WB;
        end else if (opc[OPC_LOAD] || opc[OPC_STORE]) begin
          alu_b_sel = 1'b1;
          state_d   = MEM;
        end else if (opc[OPC_BRANCH]) begin
          pc_we    = 1'b1;
          pc_sel_d = branch_taken ? PC_REL : PC_PLUS4;
          retire   = 1'b1;
          state_d  = FETCH;
        end else if (opc[OPC_JAL] || opc[OPC_JALR]) begin
          pc_we    = 1'b1;
          pc_sel_d = opc[OPC_JALR] ? PC_JALR : PC_REL;
          rf_we    = 1'b1;
          wb_sel_d = WB_PC4;
          retire   = 1'b1;
          state_d  = FETCH;
        end else begin
          // MISC_MEM (FENCE) retires as a plain PC+4 NOP.
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = opc[OPC_STORE];
        if (dmem_gnt)      state_d = DWAIT;
        else if (dmem_exp) begin state_d = TRAP; cause_d = CAUSE_BUS; end
      end
      DWAIT: begin
        if (dmem_rvalid) begin
          if (opc[OPC_STORE]) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (dmem_exp) begin
          state_d = TRAP; cause_d = CAUSE_BUS;
        end
      end
      WB: begin
        // ALU operand selects are held so the result stays valid through writeback.
        alu_a_sel = opc[OPC_AUIPC];
        alu_b_sel = opc[OPC_AUIPC] | opc[OPC_OP_IMM] | opc[OPC_LUI];
        rf_we     = 1'b1;
        wb_sel_d  = opc[OPC_LOAD] ? WB_MEM : WB_ALU;
        pc_we     = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      TRAP: trap = 1'b1;
      default: state_d = FETCH;
    endcase
    if (rst) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel_d  = PC_PLUS4;
      alu_a_sel = 1'b0;
      alu_b_sel = 1'b0;
      rf_we     = 1'b0;
      wb_sel_d  = WB_ALU;
      retire    = 1'b0;
      trap      = 1'b0;
    end
  end

  assign pc_sel     = pc_sel_d;
  assign wb_sel     = wb_sel_d;
  assign trap_cause = rst ? 2'b00 : cause_q;

endmodule

// File: tb/tb_mc_core_ctrl.sv
// Directed cycle-by-cycle bench for mc_core_ctrl with hand-computed output vectors.
module tb_mc_core_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [20:0] opc = '0;
  logic        branch_taken = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic        dmem_req, dmem_we, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic        ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, retire, trap;
  logic [1:0]  pc_sel, wb_sel, trap_cause;

  mc_core_ctrl #(.MEM_TIMEOUT(16), .TCNT_W(8)) dut (
    .clk(clk), .rst(rst), .opc(opc), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .rf_we(rf_we), .wb_sel(wb_sel), .retire(retire),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  // Output vector layout: {imem_req,dmem_req,dmem_we,ir_we,pc_we,pc_sel,a,b,rf_we,wb_sel,retire,trap,cause}
  localparam logic [15:0] IREQ = 16'h8000, DREQ = 16'h4000, DWE  = 16'h2000, IRWE = 16'h1000;
  localparam logic [15:0] PCWE = 16'h0800, PCS1 = 16'h0200, PCS2 = 16'h0400, ASEL = 16'h0100;
  localparam logic [15:0] BSEL = 16'h0080, RFWE = 16'h0040, WB1  = 16'h0010, WB2  = 16'h0020;
  localparam logic [15:0] RET  = 16'h0008, TRP  = 16'h0004, C1   = 16'h0001, C2   = 16'h0002;
  localparam logic [15:0] C3   = 16'h0003, NONE = 16'h0000;

  localparam logic [20:0] O_LOAD     = 21'd1 << mc_core_ctrl_pkg::OPC_LOAD;
  localparam logic [20:0] O_STORE    = 21'd1 << mc_core_ctrl_pkg::OPC_STORE;
  localparam logic [20:0] O_OP       = 21'd1 << mc_core_ctrl_pkg::OPC_OP;
  localparam logic [20:0] O_OP_IMM   = 21'd1 << mc_core_ctrl_pkg::OPC_OP_IMM;
  localparam logic [20:0] O_AUIPC    = 21'd1 << mc_core_ctrl_pkg::OPC_AUIPC;
  localparam logic [20:0] O_BRANCH   = 21'd1 << mc_core_ctrl_pkg::OPC_BRANCH;
  localparam logic [20:0] O_JAL      = 21'd1 << mc_core_ctrl_pkg::OPC_JAL;
  localparam logic [20:0] O_JALR     = 21'd1 << mc_core_ctrl_pkg::OPC_JALR;
  localparam logic [20:0] O_MISC_MEM = 21'd1 << mc_core_ctrl_pkg::OPC_MISC_MEM;
  localparam logic [20:0] O_OP_FP    = 21'd1 << mc_core_ctrl_pkg::OPC_OP_FP;
  localparam logic [20:0] O_SYSTEM   = 21'd1 << mc_core_ctrl_pkg::OPC_SYSTEM;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [15:0] outs;
  assign outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                 rf_we, wb_sel, retire, trap, trap_cause};

  // Checks the current cycle at the falling edge, then advances to just after the next rising edge.
  task automatic step(input string tag, input logic [15:0] exp);
    @(negedge clk);
    tests++;
    assert (outs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, outs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input int unsigned gw, input int unsigned rw,
                       input logic [20:0] op);
    for (int unsigned i = 0; i <= gw; i++) begin
      imem_gnt = (i == gw);
      step({tag, ":fetch"}, IREQ);
    end
    imem_gnt = 1'b0;
    for (int unsigned i = 0; i <= rw; i++) begin
      imem_rvalid = (i == rw);
      step({tag, ":iwait"}, (i == rw) ? IRWE : NONE);
    end
    imem_rvalid = 1'b0;
    opc = op;
    step({tag, ":decode"}, NONE);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step(tag, NONE);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL bench_timeout: observed no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset("reset");

    fetch("addi", 1, 1, O_OP_IMM);
    step("addi:exec", BSEL);
    step("addi:wb", BSEL | RFWE | PCWE | RET);

    fetch("add", 0, 0, O_OP);
    step("add:exec", NONE);
    step("add:wb", RFWE | PCWE | RET);

    fetch("auipc", 0, 0, O_AUIPC);
    step("auipc:exec", ASEL | BSEL);
    step("auipc:wb", ASEL | BSEL | RFWE | PCWE | RET);

    fetch("lw", 0, 0, O_LOAD);
    step("lw:exec", BSEL);
    for (int unsigned i = 0; i < 3; i++) begin
      imem_rvalid = (i == 0);
      step("lw:mem_hold", DREQ);
    end
    imem_rvalid = 1'b0;
    dmem_gnt = 1'b1;
    step("lw:mem_gnt", DREQ);
    dmem_gnt = 1'b0;
    step("lw:dwait", NONE);
    dmem_rvalid = 1'b1;
    step("lw:dwait_rv", NONE);
    dmem_rvalid = 1'b0;
    step("lw:wb", RFWE | WB1 | PCWE | RET);

    fetch("sw", 0, 0, O_STORE);
    step("sw:exec", BSEL);
    dmem_gnt = 1'b1;
    step("sw:mem", DREQ | DWE);
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    step("sw:dwait", PCWE | RET);
    dmem_rvalid = 1'b0;

    fetch("beq_t", 0, 0, O_BRANCH);
    branch_taken = 1'b1;
    step("beq_t:exec", PCWE | PCS1 | RET);
    branch_taken = 1'b0;
    fetch("beq_n", 0, 0, O_BRANCH);
    step("beq_n:exec", PCWE | RET);

    fetch("jalr", 0, 0, O_JALR);
    step("jalr:exec", PCWE | PCS2 | RFWE | WB2 | RET);
    fetch("jal", 0, 0, O_JAL);
    step("jal:exec", PCWE | PCS1 | RFWE | WB2 | RET);

    // Grant on the 16th request cycle still completes the fetch.
    fetch("late_gnt", 15, 0, O_MISC_MEM);
    step("late_gnt:exec", PCWE | RET);

    fetch("rst_dw", 0, 0, O_LOAD);
    step("rst_dw:exec", BSEL);
    dmem_gnt = 1'b1;
    step("rst_dw:mem", DREQ);
    dmem_gnt = 1'b0;
    step("rst_dw:dwait", NONE);
    rst = 1'b1;
    step("rst_dw:in_rst", NONE);
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    step("rst_dw:fetch", IREQ);
    dmem_rvalid = 1'b0;
    fetch("post_rst", 0, 0, O_MISC_MEM);
    step("post_rst:exec", PCWE | RET);

    fetch("opfp", 0, 0, O_OP_FP);
    for (int unsigned i = 0; i < 3; i++) step("opfp:trap", TRP | C1);
    do_reset("opfp:reset");

    fetch("opc0", 0, 0, 21'd0);
    step("opc0:trap", TRP | C1);
    do_reset("opc0:reset");

    fetch("twohot", 0, 0, O_OP | O_OP_IMM);
    step("twohot:trap", TRP | C1);
    do_reset("twohot:reset");

    fetch("ecall", 0, 0, O_SYSTEM);
    step("ecall:trap", TRP | C2);
    step("ecall:hold", TRP | C2);
    do_reset("ecall:reset");

    for (int unsigned i = 0; i < 16; i++) step("igto:req", IREQ);
    step("igto:trap", TRP | C3);
    step("igto:hold", TRP | C3);
    do_reset("igto:reset");

    imem_gnt = 1'b1;
    step("rvto:fetch", IREQ);
    imem_gnt = 1'b0;
    for (int unsigned i = 0; i < 16; i++) step("rvto:iwait", NONE);
    step("rvto:trap", TRP | C3);
    do_reset("rvto:reset");

    fetch("dgto", 0, 0, O_STORE);
    step("dgto:exec", BSEL);
    for (int unsigned i = 0; i < 16; i++) step("dgto:req", DREQ | DWE);
    step("dgto:trap", TRP | C3);
    do_reset("dgto:reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
